// File: rtl/regfile_mp_sb.sv
// ---------------------------------------------------------------------------
// regfile_mp_sb
//   Multi-port register file for the pipelined MIPS datapath, with a busy
//   scoreboard that decode uses to detect RAW hazards.
//   Storage has two write ports and N_RD combinational read ports. On an
//   address collision, write port 1 has priority. Write data can optionally
//   be forwarded to the read ports in the same cycle. Register 0 can
//   optionally be hardwired to zero.
//
// Ports
//   CLK        in   rising-edge clock
//   reset      in   asynchronous, active-low reset (clears data and busy)
//   ra         in   N_RD packed read addresses, port i = ra[i*ADDR_W +: ADDR_W]
//   rd         out  N_RD packed read data,      port i = rd[i*DATA_W +: DATA_W]
//   rbusy      out  scoreboard busy flag for each read address
//   we0/wa0/wd0     write port 0
//   we1/wa1/wd1     write port 1 (wins over port 0 on the same address)
//   claim_en   in   mark claim_addr busy (a producer of that register issued)
//   claim_addr in   register being claimed
// ---------------------------------------------------------------------------
module regfile_mp_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int N_RD     = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                     CLK,
  input  logic                     reset,
  input  logic [N_RD*ADDR_W-1:0]   ra,
  output logic [N_RD*DATA_W-1:0]   rd,
  output logic [N_RD-1:0]          rbusy,
  input  logic                     we0,
  input  logic [ADDR_W-1:0]        wa0,
  input  logic [DATA_W-1:0]        wd0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        wa1,
  input  logic [DATA_W-1:0]        wd1,
  input  logic                     claim_en,
  input  logic [ADDR_W-1:0]        claim_addr
);

  localparam int   DEPTH = 2**ADDR_W;
  localparam logic BP    = (BYPASS != 0);
  localparam logic ZR    = (ZERO_REG != 0);

  // Reject unsupported read-port counts at elaboration time.
  if ((N_RD < 1) || (N_RD > 4)) begin : g_bad_nrd
    $error("regfile_mp_sb: N_RD must be in 1..4");
  end

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]  r_busy;

  logic              w_we0_eff;
  logic              w_we1_eff;
  logic              w_claim_eff;
  logic [DEPTH-1:0]  w_busy_set;
  logic [DEPTH-1:0]  w_busy_clr;
  logic [DEPTH-1:0]  w_busy_nxt;

  // With a hardwired zero register, writes and claims of address 0 are dropped.
  assign w_we0_eff   = we0      & ~(ZR & (wa0        == '0));
  assign w_we1_eff   = we1      & ~(ZR & (wa1        == '0));
  assign w_claim_eff = claim_en & ~(ZR & (claim_addr == '0));

  // A claim and a writeback to the same register in one cycle leave the bit
  // set, because the claim belongs to a newer producer than the one that is
  // writing back.
  assign w_busy_set = DEPTH'(w_claim_eff) << claim_addr;
  assign w_busy_clr = (DEPTH'(w_we0_eff) << wa0) | (DEPTH'(w_we1_eff) << wa1);
  assign w_busy_nxt = (r_busy & ~w_busy_clr) | w_busy_set;

  // Storage and scoreboard update. Port 1 is written last, so it wins a collision.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_busy <= '0;
    end else begin
      if (w_we0_eff) begin
        r_mem[wa0] <= wd0;
      end
      if (w_we1_eff) begin
        r_mem[wa1] <= wd1;
      end
      r_busy <= w_busy_nxt;
    end
  end

  for (genvar p = 0; p < N_RD; p++) begin : g_rd
    logic [ADDR_W-1:0] w_ra;
    logic              w_hit0;
    logic              w_hit1;
    logic [DATA_W-1:0] w_rd;
    logic              w_rbusy;

    assign w_ra   = ra[p*ADDR_W +: ADDR_W];
    assign w_hit0 = BP & we0 & (wa0 == w_ra);
    assign w_hit1 = BP & we1 & (wa1 == w_ra);

    // Per-port read mux. Forwarded data has no outstanding hazard, so busy is masked on a hit.
    always_comb begin
      w_rd    = r_mem[w_ra];
      w_rbusy = r_busy[w_ra];
      if (ZR && (w_ra == '0)) begin
        w_rd    = '0;
        w_rbusy = 1'b0;
      end else if (w_hit1) begin
        w_rd    = wd1;
        w_rbusy = 1'b0;
      end else if (w_hit0) begin
        w_rd    = wd0;
        w_rbusy = 1'b0;
      end else begin
        w_rd    = r_mem[w_ra];
        w_rbusy = r_busy[w_ra];
      end
    end

    assign rd[p*DATA_W +: DATA_W] = w_rd;
    assign rbusy[p]               = w_rbusy;
  end

endmodule
